// File: rtl/dmac_ahbl_slave_if.sv
// AHB-Lite bus bundle between a manager and the DMA controller's register slave.
interface dmac_ahbl_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/dmac_ahbl_slave.sv
// DMA controller register file behind a zero-wait-state AHB-Lite slave.
// Holds transfer descriptors, issues a one-cycle start pulse and latches
// engine completion into a sticky DONE flag that can raise an interrupt.
module dmac_ahbl_slave (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  dmac_ahbl_slave_if.slave        bus,
  output logic [31:0]             saddr,
  output logic [31:0]             daddr,
  output logic [2:0]              ssize,
  output logic [2:0]              dsize,
  output logic [2:0]              sinc,
  output logic [2:0]              dinc,
  output logic [7:0]              bsize,
  output logic [7:0]              bcount,
  output logic                    wfi,
  output logic [2:0]              irqsrc,
  output logic                    start,
  input  logic                    done,
  input  logic                    busy,
  output logic                    irq
);

  localparam logic [2:0]  OFF_SADDR  = 3'd0;
  localparam logic [2:0]  OFF_DADDR  = 3'd1;
  localparam logic [2:0]  OFF_CTRL   = 3'd2;
  localparam logic [2:0]  OFF_BSIZE  = 3'd3;
  localparam logic [2:0]  OFF_BCOUNT = 3'd4;
  localparam logic [2:0]  OFF_START  = 3'd5;
  localparam logic [2:0]  OFF_STATUS = 3'd6;
  localparam logic [2:0]  OFF_IM     = 3'd7;
  // Implemented CTRL bits: irqsrc[22:20], wfi[16], dinc, sinc, dsize, ssize.
  localparam logic [31:0] CTRL_MASK  = 32'h0071_7777;

  // Captured address-phase attributes, live during the data phase
  logic        valid_q;
  logic [2:0]  woff_q;
  logic [2:0]  size_q;
  logic [1:0]  boff_q;
  logic        write_q;

  // Register state and next-state
  logic [31:0] saddr_q,  saddr_d;
  logic [31:0] daddr_q,  daddr_d;
  logic [31:0] ctrl_q,   ctrl_d;
  logic [7:0]  bsize_q,  bsize_d;
  logic [7:0]  bcount_q, bcount_d;
  logic        start_q,  start_d;
  logic        done_q,   done_d;
  logic        im_q,     im_d;

  logic        accept;
  logic        wr_en;
  logic [3:0]  be;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic        unused_addr;

  assign accept      = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign unused_addr = ^bus.HADDR[31:5];

  // Capture the address phase; the valid flag drops on any non-accepted edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      woff_q  <= 3'd0;
      size_q  <= 3'd0;
      boff_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        woff_q  <= bus.HADDR[4:2];
        size_q  <= bus.HSIZE;
        boff_q  <= bus.HADDR[1:0];
        write_q <= bus.HWRITE;
      end
    end
  end

  // Byte-lane enables for the current data phase, expanded to a bit mask
  always_comb begin
    be = 4'b1111;
    if (size_q == 3'd0)      be = 4'b0001 << boff_q;
    else if (size_q == 3'd1) be = boff_q[1] ? 4'b1100 : 4'b0011;
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  assign wr_en = valid_q & write_q;

  // Next-state for all registers: lane-merged writes, start pulse, sticky DONE
  always_comb begin
    saddr_d  = saddr_q;
    daddr_d  = daddr_q;
    ctrl_d   = ctrl_q;
    bsize_d  = bsize_q;
    bcount_d = bcount_q;
    im_d     = im_q;
    start_d  = 1'b0;
    done_d   = done_q;
    if (wr_en) begin
      case (woff_q)
        OFF_SADDR:  saddr_d  = (saddr_q & ~wmask) | (bus.HWDATA & wmask);
        OFF_DADDR:  daddr_d  = (daddr_q & ~wmask) | (bus.HWDATA & wmask);
        OFF_CTRL:   ctrl_d   = ((ctrl_q & ~wmask) | (bus.HWDATA & wmask)) & CTRL_MASK;
        OFF_BSIZE:  bsize_d  = (bsize_q & ~wmask[7:0]) | (bus.HWDATA[7:0] & wmask[7:0]);
        OFF_BCOUNT: bcount_d = (bcount_q & ~wmask[7:0]) | (bus.HWDATA[7:0] & wmask[7:0]);
        OFF_START:  start_d  = be[0] & bus.HWDATA[0] & ~busy;
        OFF_STATUS: if (be[0] && bus.HWDATA[1]) done_d = 1'b0;
        OFF_IM:     if (be[0]) im_d = bus.HWDATA[0];
        default:    ;
      endcase
    end
    // Engine completion overrides a coincident clear
    if (done) done_d = 1'b1;
  end

  // Register state update
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      saddr_q  <= 32'd0;
      daddr_q  <= 32'd0;
      ctrl_q   <= 32'd0;
      bsize_q  <= 8'd0;
      bcount_q <= 8'd0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      im_q     <= 1'b0;
    end else begin
      saddr_q  <= saddr_d;
      daddr_q  <= daddr_d;
      ctrl_q   <= ctrl_d;
      bsize_q  <= bsize_d;
      bcount_q <= bcount_d;
      start_q  <= start_d;
      done_q   <= done_d;
      im_q     <= im_d;
    end
  end

  // Read mux on the captured word offset; zero outside a valid data phase
  always_comb begin
    rdata = 32'd0;
    case (woff_q)
      OFF_SADDR:  rdata = saddr_q;
      OFF_DADDR:  rdata = daddr_q;
      OFF_CTRL:   rdata = ctrl_q;
      OFF_BSIZE:  rdata = {24'd0, bsize_q};
      OFF_BCOUNT: rdata = {24'd0, bcount_q};
      OFF_STATUS: rdata = {30'd0, done_q, busy};
      OFF_IM:     rdata = {31'd0, im_q};
      default:    rdata = 32'd0;
    endcase
    if (!valid_q) rdata = 32'd0;
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign saddr  = saddr_q;
  assign daddr  = daddr_q;
  assign ssize  = ctrl_q[2:0];
  assign dsize  = ctrl_q[6:4];
  assign sinc   = ctrl_q[10:8];
  assign dinc   = ctrl_q[14:12];
  assign wfi    = ctrl_q[16];
  assign irqsrc = ctrl_q[22:20];
  assign bsize  = bsize_q;
  assign bcount = bcount_q;
  assign start  = start_q;
  assign irq    = done_q & im_q;

endmodule

// File: tb/tb_dmac_ahbl_slave.sv
// Directed bench for the DMA controller register slave.
module tb_dmac_ahbl_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        done = 1'b0;
  logic        busy = 1'b0;
  logic [31:0] saddr, daddr;
  logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
  logic [7:0]  bsize, bcount;
  logic        wfi, start, irq;

  int n_chk  = 0;
  int n_pass = 0;

  dmac_ahbl_slave_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  dmac_ahbl_slave dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .saddr   (saddr),
    .daddr   (daddr),
    .ssize   (ssize),
    .dsize   (dsize),
    .sinc    (sinc),
    .dinc    (dinc),
    .bsize   (bsize),
    .bcount  (bcount),
    .wfi     (wfi),
    .irqsrc  (irqsrc),
    .start   (start),
    .done    (done),
    .busy    (busy),
    .irq     (irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = 32'd0;
    bus.HSIZE  = 3'd2;
    bus.HWRITE = 1'b0;
  endtask

  // Single non-pipelined transfer; returns with #1 after the data-phase end edge
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HWRITE = wr;
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = wdata;
    rdata = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] unused_rd;
    xfer(1'b1, addr, 3'd2, data, unused_rd);
  endtask

  task automatic rd32(input logic [31:0] addr, output logic [31:0] data);
    xfer(1'b0, addr, 3'd2, 32'd0, data);
  endtask

  initial begin
    logic [31:0] rd;
    bus_idle();
    bus.HWDATA = 32'd0;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hrdata", bus.HRDATA, 32'd0);
    chk("rst_saddr",  saddr, 32'd0);
    chk("rst_start",  {31'd0, start}, 32'd0);
    chk("rst_irq",    {31'd0, irq}, 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Back-to-back write then read of SADDR
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0; bus.HSIZE = 3'd2; bus.HWRITE = 1'b1;
    @(posedge HCLK); #1;
    bus.HWDATA = 32'h1000_0000;
    bus.HWRITE = 1'b0;
    @(posedge HCLK); #1;
    bus_idle();
    chk("b2b_rdata",  bus.HRDATA, 32'h1000_0000);
    chk("b2b_ready",  {31'd0, bus.HREADYOUT}, 32'd1);
    chk("b2b_saddr",  saddr, 32'h1000_0000);
    @(posedge HCLK); #1;
    chk("idle_hrdata", bus.HRDATA, 32'd0);

    // Byte write to CTRL lane 1 with all lanes carrying data
    xfer(1'b1, 32'h09, 3'd0, 32'hABAB_ABAB, rd);
    rd32(32'h08, rd);
    chk("ctrl_byte", rd, 32'h0000_2300);
    chk("ctrl_sinc", {29'd0, sinc}, 32'd3);
    chk("ctrl_dinc", {29'd0, dinc}, 32'd2);
    chk("ctrl_ssize", {29'd0, ssize}, 32'd0);
    wr32(32'h08, 32'hFFFF_FFFF);
    rd32(32'h08, rd);
    chk("ctrl_mask", rd, 32'h0071_7777);
    chk("ctrl_irqsrc", {28'd0, wfi, irqsrc}, 32'hF);

    // Halfword lanes on BSIZE, word write on BCOUNT
    wr32(32'h0C, 32'hFFFF_FF5A);
    xfer(1'b1, 32'h0E, 3'd1, 32'h1234_00FF, rd);
    rd32(32'h0C, rd);
    chk("bsize_hw", rd, 32'h0000_005A);
    xfer(1'b1, 32'h0C, 3'd1, 32'h0000_0033, rd);
    chk("bsize_lo", {24'd0, bsize}, 32'h33);
    wr32(32'h10, 32'hFFFF_FF81);
    rd32(32'h10, rd);
    chk("bcount", rd, 32'h0000_0081);

    // Start pulse while idle, suppressed while busy
    wr32(32'h14, 32'h1);
    chk("start_hi", {31'd0, start}, 32'd1);
    @(posedge HCLK); #1;
    chk("start_lo", {31'd0, start}, 32'd0);
    busy = 1'b1;
    wr32(32'h14, 32'h1);
    chk("start_busy", {31'd0, start}, 32'd0);
    @(posedge HCLK); #1;
    chk("start_busy2", {31'd0, start}, 32'd0);
    rd32(32'h18, rd);
    chk("status_busy", rd, 32'h1);
    busy = 1'b0;
    rd32(32'h14, rd);
    chk("start_rd0", rd, 32'd0);

    // DONE, IM, irq and W1C
    wr32(32'h1C, 32'hFFFF_FFFF);
    chk("irq_nodone", {31'd0, irq}, 32'd0);
    done = 1'b1; @(posedge HCLK); #1; done = 1'b0;
    rd32(32'h18, rd);
    chk("status_done", rd, 32'h2);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr32(32'h18, 32'h2);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd32(32'h18, rd);
    chk("status_clr", rd, 32'h0);
    done = 1'b1;
    wr32(32'h18, 32'h2);
    done = 1'b0;
    rd32(32'h18, rd);
    chk("w1c_race", rd, 32'h2);
    chk("irq_race", {31'd0, irq}, 32'd1);

    // IM reads only bit 0; masking irq
    rd32(32'h1C, rd);
    chk("im_rd", rd, 32'h1);
    chk("hresp", {31'd0, bus.HRESP}, 32'd0);
    wr32(32'h1C, 32'h0);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr32(32'h18, 32'h2);

    // Reset in the middle of a DADDR write data phase
    wr32(32'h04, 32'h0000_5555);
    chk("daddr_pre", daddr, 32'h0000_5555);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h04; bus.HSIZE = 3'd2; bus.HWRITE = 1'b1;
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'hDEAD_BEEF;
    #2 HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_start2", {31'd0, start}, 32'd0);
    chk("rst_irq2", {31'd0, irq}, 32'd0);
    rd32(32'h04, rd);
    chk("rst_daddr_rd", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmac_ahbl_slave.md
DMAC_AHBL_SLAVE -- requirements
Module: dmac_ahbl_slave

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port HCLK, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have AHB-Lite responder inputs, one per line:
- HSEL, input, 1: slave select.
- HADDR, input, 32: address; only bits [4:0] decoded.
- HTRANS, input, 2: transfer type.
- HSIZE, input, 3: transfer size.
- HWRITE, input, 1: write indicator.
- HWDATA, input, 32: write data.
- HREADY, input, 1: bus ready.
REQ-005 SHALL have AHB-Lite responder outputs, one per line:
- HREADYOUT, output, 1: constant 1, zero wait states.
- HRDATA, output, 32: read data.
- HRESP, output, 1: constant 0, OKAY.
REQ-006 SHALL have DMA-engine-facing outputs, one per line:
- saddr, output, 32: source address.
- daddr, output, 32: destination address.
- ssize, output, 3: source transfer size.
- dsize, output, 3: destination transfer size.
- sinc, output, 3: source address increment.
- dinc, output, 3: destination address increment.
- bsize, output, 8: block size.
- bcount, output, 8: block count.
- wfi, output, 1: wait-for-interrupt enable.
- irqsrc, output, 3: peripheral interrupt select.
- start, output, 1: one-cycle start pulse.
REQ-007 SHALL have DMA-engine-facing inputs: done, input, 1 (completion pulse); busy, input, 1 (engine active).
REQ-008 SHALL have port irq, output, 1: interrupt to CPU.

Function
REQ-009 SHALL capture an address phase (HADDR[4:2], HSIZE, HADDR[1:0], HWRITE) only when HSEL & HTRANS[1] & HREADY; otherwise the data-phase valid flag clears on that edge.
REQ-010 SHALL perform the register write at the end of the data phase (edge following capture) using HWDATA, honoring byte lanes:
- HSIZE=0: one byte lane selected by HADDR[1:0].
- HSIZE=1: one halfword selected by HADDR[1].
- HSIZE=2: all lanes.
REQ-011 SHALL drive HRDATA combinationally from the captured word offset during the data phase, full 32-bit word, regardless of size.
REQ-012 SHALL use this register map (offset: field bits):
- 0x00 SADDR[31:0]; 0x04 DADDR[31:0].
- 0x08 CTRL: ssize[2:0], dsize[6:4], sinc[10:8], dinc[14:12], wfi[16], irqsrc[22:20].
- 0x0C BSIZE[7:0]; 0x10 BCOUNT[7:0].
- 0x14 START: write-only, reads 0.
- 0x18 STATUS: busy[0] read-only, DONE[1] sticky, write-1-to-clear.
- 0x1C IM[0]: interrupt mask.
REQ-013 SHALL read unimplemented bits and unmapped offsets as 0, ignore writes to them, and always return OKAY.
REQ-014 SHALL assert start for exactly one cycle, the cycle after a START write with HWDATA[0]=1 and busy=0; a START write while busy=1 SHALL be ignored.
REQ-015 SHALL set DONE on any cycle with done=1; when set and W1C occur in the same cycle, set SHALL win.
REQ-016 SHALL drive irq = DONE & IM as a registered-state combinational AND, level-sensitive.
REQ-017 SHALL support back-to-back transfers: a data phase and the next address phase in the same cycle; a read immediately after a write to the same offset SHALL return the newly written value.
REQ-018 SHALL ignore IDLE/BUSY HTRANS, and HSEL=0, with no register side effects.

Reset
REQ-019 SHALL, on HRESETn low, asynchronously clear all registers, DONE, IM, start and the data-phase valid flag to 0; HRDATA SHALL read 0 while no data phase is valid.
REQ-020 SHALL, on reset during an active data phase, discard that write.

Verification
REQ-021 Write 0x1000_0000 to 0x00, then read 0x00 back-to-back -> HRDATA=0x1000_0000 with zero wait states.
REQ-022 Byte write 0xAB at 0x09 (HSIZE=0), CTRL previously 0 -> CTRL reads 0x0000_AB00 masked to implemented bits = 0x0000_2300.
REQ-023 Write 1 to 0x14 with busy=0 -> start high exactly 1 cycle; repeat with busy=1 -> start stays 0.
REQ-024 Pulse done, IM=1 -> STATUS reads 0x2, irq=1; write 0x2 to 0x18 -> irq=0; W1C coincident with done -> DONE stays 1.
REQ-025 Read 0x1C..0x1F unmapped-bit region and write to offset 0x14 reads -> value 0, HRESP=0.
REQ-026 Assert HRESETn low mid-write to 0x04 -> DADDR=0, no start, irq=0 after release.
